// File: rtl/sdram_axi_pkg.sv
// Shared AXI constants, tester FSM states and the data pattern used by the
// SDRAM AXI traffic generator/checker.
package sdram_axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_LEN_W  = 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW,
    WR_W,
    WR_B,
    RD_AR,
    RD_R,
    DONE
  } tester_state_e;

  function automatic logic [AXI_DATA_W-1:0] axi_pattern(input logic [AXI_ADDR_W-1:0] addr,
                                                        input logic [AXI_DATA_W-1:0] mask);
    return addr ^ mask;
  endfunction

endpackage

// File: rtl/sdram_tester_chk.sv
// Error accounting for the tester: saturating error counter and capture of
// the address of the first failing beat or write response.
module sdram_tester_chk
  import sdram_axi_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  beat_valid,
  input  logic [AXI_DATA_W-1:0] exp_data,
  input  logic [AXI_DATA_W-1:0] act_data,
  input  logic [1:0]            resp,
  input  logic                  last_mismatch,
  input  logic [AXI_ADDR_W-1:0] err_addr,
  output logic [15:0]           err_count,
  output logic [AXI_ADDR_W-1:0] first_err_addr
);

  logic beat_err;

  assign beat_err = beat_valid &&
                    ((act_data != exp_data) || (resp != AXI_RESP_OKAY) || last_mismatch);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (clear) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (beat_err) begin
      // Only the very first error of a run is recorded.
      if (err_count == '0) first_err_addr <= err_addr;
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: rtl/sdram_axi_tester.sv
// AXI4 master that writes an address-derived pattern over a region in INCR
// bursts, reads it back and reports pass/fail with error statistics.
module sdram_axi_tester
  import sdram_axi_pkg::*;
#(
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned           NUM_BURSTS = 256,
  parameter int unsigned           BURST_LEN  = 16,
  parameter logic [AXI_DATA_W-1:0] PAT_XOR    = 32'hA5A5_5A5A,
  parameter logic [AXI_ID_W-1:0]   AXI_ID     = 4'h0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [AXI_ADDR_W-1:0] first_err_addr,
  output logic [AXI_ID_W-1:0]   awid,
  output logic [AXI_ADDR_W-1:0] awaddr,
  output logic [AXI_LEN_W-1:0]  awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [AXI_DATA_W-1:0] wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [AXI_ID_W-1:0]   bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [AXI_ID_W-1:0]   arid,
  output logic [AXI_ADDR_W-1:0] araddr,
  output logic [AXI_LEN_W-1:0]  arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [AXI_ID_W-1:0]   rid,
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam logic [8:0]            LAST_BEAT   = 9'(BURST_LEN - 1);
  localparam logic [15:0]           LAST_BURST  = 16'(NUM_BURSTS - 1);
  localparam logic [AXI_ADDR_W-1:0] BURST_BYTES = AXI_ADDR_W'(4 * BURST_LEN);

  tester_state_e         state, state_nxt;
  logic [AXI_ADDR_W-1:0] burst_addr;
  logic [15:0]           burst_cnt;
  logic [8:0]            beat_cnt;
  logic [AXI_ADDR_W-1:0] beat_addr;
  logic [AXI_DATA_W-1:0] exp_data;
  logic                  is_last_beat, is_last_burst;
  logic                  start_ok, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  unused_ids;

  assign unused_ids = ^{bid, rid};

  assign beat_addr     = burst_addr + {21'd0, beat_cnt, 2'b00};
  assign exp_data      = axi_pattern(beat_addr, PAT_XOR);
  assign is_last_beat  = (beat_cnt == LAST_BEAT);
  assign is_last_burst = (burst_cnt == LAST_BURST);

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign b_hs     = bready && bvalid;
  assign ar_hs    = arvalid && arready;
  assign r_hs     = rready && rvalid;

  assign awid    = AXI_ID;
  assign arid    = AXI_ID;
  assign awlen   = AXI_LEN_W'(BURST_LEN - 1);
  assign arlen   = AXI_LEN_W'(BURST_LEN - 1);
  assign awsize  = AXI_SIZE_4B;
  assign arsize  = AXI_SIZE_4B;
  assign awburst = AXI_BURST_INCR;
  assign arburst = AXI_BURST_INCR;
  assign awprot  = 3'b000;
  assign arprot  = 3'b000;
  assign wstrb   = 4'hF;
  assign awaddr  = burst_addr;
  assign araddr  = burst_addr;
  assign wdata   = exp_data;
  assign wlast   = is_last_beat;

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_nxt = state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = WR_AW;
      WR_AW: begin
        awvalid = 1'b1;
        if (awready) state_nxt = WR_W;
      end
      WR_W: begin
        wvalid = 1'b1;
        if (wready && is_last_beat) state_nxt = WR_B;
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = is_last_burst ? RD_AR : WR_AW;
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RD_R;
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid && is_last_beat) state_nxt = is_last_burst ? DONE : RD_AR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_addr <= '0;
      burst_cnt  <= '0;
      beat_cnt   <= '0;
    end else begin
      if (start_ok) begin
        burst_addr <= BASE_ADDR;
        burst_cnt  <= '0;
        beat_cnt   <= '0;
      end
      if (aw_hs || ar_hs) beat_cnt <= '0;
      if (w_hs || r_hs)   beat_cnt <= beat_cnt + 9'd1;
      // The read burst ends on its counted last beat, independent of rlast.
      if (b_hs || (r_hs && is_last_beat)) begin
        if (is_last_burst) begin
          burst_addr <= BASE_ADDR;
          burst_cnt  <= '0;
        end else begin
          burst_addr <= burst_addr + BURST_BYTES;
          burst_cnt  <= burst_cnt + 16'd1;
        end
      end
    end
  end

  sdram_tester_chk u_chk (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (start_ok),
    .beat_valid     (b_hs || r_hs),
    .exp_data       (exp_data),
    .act_data       (r_hs ? rdata : exp_data),
    .resp           (r_hs ? rresp : bresp),
    .last_mismatch  (r_hs && (rlast != is_last_beat)),
    .err_addr       (r_hs ? beat_addr : burst_addr),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

endmodule

// File: doc/sdram_axi_tester.md
Name: sdram_axi_tester

Overview:
- AXI4 master traffic generator and checker that sits directly upstream of my_sdram_axi, in place of or alongside the JTAG bridge.
- On start, it writes an address-derived pattern over a region using INCR bursts, then reads the region back and compares every beat.
- It reports pass/fail, an error count and the first failing address.
- It is used for board bring-up and regression of the SDRAM controller without a host.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of first burst (must be 4-byte aligned).
- NUM_BURSTS, 256, bursts per phase (1..65535).
- BURST_LEN, 16, beats per burst (1..256); awlen/arlen = BURST_LEN-1.
- PAT_XOR, 32'hA5A5_5A5A, XOR mask applied to the beat address to form the data.
- AXI_ID, 4'h0, constant awid/arid.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a test when idle or done
- busy  out  1  test in progress
- done  out  1  test finished; held until next start
- pass  out  1  valid when done; 1 iff err_count==0
- err_count  out  16  saturating mismatch/response-error count
- first_err_addr  out  32  byte address of first error
- awid/awaddr/awlen/awsize/awburst/awprot/awvalid  out  4/32/8/3/2/3/1  AXI write address
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI write data
- wready  in  1
- bid/bresp/bvalid  in  4/2/1
- bready  out  1
- arid/araddr/arlen/arsize/arburst/arprot/arvalid  out  4/32/8/3/2/3/1  AXI read address
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1
- rready  out  1

Behaviour:
- Reset (async assert, sync release): state IDLE. All valids, bready, rready, busy, done and pass are 0. err_count is 0 and first_err_addr is 0. Addresses and counters are cleared.
- Constant outputs: awsize=arsize=3'b010, awburst=arburst=2'b01 (INCR), awprot=arprot=3'b000, wstrb=4'hF, awid=arid=AXI_ID.
- FSM states: IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, DONE. One burst is outstanding at a time, and W never overlaps AW.
- IDLE/DONE, start=1:
  - Clear err_count, first_err_addr, pass and done.
  - Set burst_addr=BASE_ADDR and burst_cnt=0.
  - Go to WR_AW, with busy=1 from the next cycle.
  - start is ignored in all other states.
- WR_AW:
  - awvalid=1, awaddr=burst_addr, held stable until awready.
  - On handshake: awvalid=0, beat_cnt=0, go to WR_W.
- WR_W:
  - wvalid=1, wdata=(burst_addr+4*beat_cnt)^PAT_XOR, wlast=(beat_cnt==BURST_LEN-1).
  - Data is held stable until wready.
  - On handshake: beat_cnt++; after the last beat go to WR_B.
- WR_B:
  - bready=1.
  - On bvalid, bresp!=2'b00 counts as one error at burst_addr.
  - Then burst_addr += 4*BURST_LEN (mod 2^32) and burst_cnt++.
  - If burst_cnt reaches NUM_BURSTS: reload burst_addr=BASE_ADDR, burst_cnt=0, go to RD_AR. Otherwise go to WR_AW.
- RD_AR: arvalid=1, araddr=burst_addr until arready, then go to RD_R with beat_cnt=0.
- RD_R: rready=1. Each rvalid beat is an error (one count per beat) if any of these holds:
  - rdata != expected pattern;
  - rresp != 2'b00;
  - rlast != (beat_cnt==BURST_LEN-1).
- RD_R advance and exit:
  - beat_cnt++ on every rvalid beat.
  - The burst ends on the beat where beat_cnt==BURST_LEN-1, regardless of rlast.
  - Then advance burst_addr/burst_cnt as in WR_B. After NUM_BURSTS go to DONE, otherwise RD_AR.
- rid and bid are ignored.
- Error capture:
  - err_count saturates at 16'hFFFF.
  - first_err_addr latches the beat address (B errors: the burst address) only while err_count==0.
  - Compare and update happen in the same cycle as the handshake; err_count is visible the next cycle.
- DONE: busy=0, done=1, pass=(err_count==0). All values are held.
- Address wrap past 32'hFFFF_FFFC rolls over to 0 silently.
- Async reset mid-burst drops all valids immediately. The downstream slave must be reset together with this block.

Decomposition:
- Shared package sdram_axi_pkg holds:
  - AXI_BURST_INCR, AXI_RESP_OKAY, AXI_SIZE_4B;
  - the FSM state enum;
  - the ID and address width constants shared with my_sdram_axi.
- One sub-module, sdram_tester_chk:
  - takes beat valid, expected data, actual data, resp and last-mismatch;
  - owns err_count saturation and first_err_addr capture.
- The pattern is a one-line function in the package.

Test Plan:
- Scenario 1, ideal memory model (awready/wready/arready always 1, 1-cycle B, zero-wait R), NUM_BURSTS=4, BURST_LEN=16, start pulse -> 64 writes with wdata = addr^A5A5_5A5A, wlast on beats 15/31/47/63, 64 reads; done=1, pass=1, err_count=0.
- Scenario 2, model corrupts rdata at byte address 0x0000_0084 -> err_count=1, first_err_addr=32'h0000_0084, pass=0.
- Scenario 3, random ready/valid stalls (0-5 cycles) on every channel -> no valid drops and no payload change while stalled; same result as scenario 1.
- Scenario 4, bresp=2'b10 on the second write burst -> err_count=1, first_err_addr=BASE_ADDR+0x40; read phase still runs.
- Scenario 5, BASE_ADDR=32'hFFFF_FFC0, NUM_BURSTS=2 -> second burst awaddr=32'h0000_0000; pass=1.
- Scenario 6, reset_n low during WR_W beat 5, then release and start again -> all outputs are at reset values while reset_n is low; the new run passes with err_count=0.
